// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Memory-access stage of the LC3 pipeline. Captures one execute-stage record
// while idle, performs the data-memory read/write it needs over a
// request/ready handshake (with an extra pointer read for LDI/STI), then
// presents a one-cycle writeback record. Upstream is stalled while busy.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   : per-request wait counter; a request that is not answered
//               within TIMEOUT_CYCLES request cycles is abandoned, the
//               writeback carries wb_en=0 / wb_data=0 and mem_err latches.
//   undefined : requests wait indefinitely, mem_err is tied low.
//
// Ports
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   enable_mem            : execute-stage record valid
//   IR_Exec, aluout,
//   pcout, M_Data         : instruction, ALU result, effective address, store data
//   W_Control_in          : writeback select (00 alu, 01 mem, 10 pc, 11 alu)
//   Mem_Control_in        : instruction uses memory
//   Data_dout, Data_ready : memory read data and completion strobe
//   Data_addr, Data_din,
//   Data_rd, Data_req     : memory request (address, write data, dir, valid)
//   mem_stall             : upstream must hold
//   wb_valid, wb_en,
//   wb_dr, wb_data        : writeback record
//   mem_err               : sticky timeout flag
//
// All outputs are registers loaded from their next-cycle values.
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_mem,
  input  logic [15:0]       IR_Exec,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] pcout,
  input  logic [DATA_W-1:0] M_Data,
  input  logic [1:0]        W_Control_in,
  input  logic              Mem_Control_in,
  input  logic [DATA_W-1:0] Data_dout,
  input  logic              Data_ready,
  output logic [DATA_W-1:0] Data_addr,
  output logic [DATA_W-1:0] Data_din,
  output logic              Data_rd,
  output logic              Data_req,
  output logic              mem_stall,
  output logic              wb_valid,
  output logic              wb_en,
  output logic [2:0]        wb_dr,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_IND_RD = 2'd1,
    S_ACCESS = 2'd2,
    S_WB     = 2'd3
  } state_t;

  // Opcode class: {is_mem, is_indirect, is_store}. Memory opcodes only count
  // when the execute stage flags the instruction as a memory user.
  function automatic logic [2:0] f_decode(input logic [3:0] op, input logic mem_ctl);
    logic [2:0] cls;
    case (op)
      4'b0010, 4'b0110: cls = 3'b100;  // LD, LDR
      4'b1010:          cls = 3'b110;  // LDI
      4'b0011, 4'b0111: cls = 3'b101;  // ST, STR
      4'b1011:          cls = 3'b111;  // STI
      default:          cls = 3'b000;
    endcase
    return mem_ctl ? cls : 3'b000;
  endfunction

  // Writeback source select; the reserved code behaves like the ALU path.
  function automatic logic [DATA_W-1:0] f_wb_sel(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] mem,
    input logic [DATA_W-1:0] pc
  );
    case (sel)
      2'b01:   return mem;
      2'b10:   return pc;
      default: return alu;
    endcase
  endfunction

  state_t            r_state;
  state_t            w_nxt_state;

  // Latched execute record (only IR[11:9] is needed after decode)
  logic [2:0]        r_ir_dr;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_mdata;
  logic [1:0]        r_wctl;
  logic              r_is_store;

  // Output registers
  logic [DATA_W-1:0] r_data_addr;
  logic [DATA_W-1:0] r_data_din;
  logic              r_data_rd;
  logic              r_data_req;
  logic              r_mem_stall;
  logic              r_wb_valid;
  logic              r_wb_en;
  logic [2:0]        r_wb_dr;
  logic [DATA_W-1:0] r_wb_data;

  logic [2:0]        w_dec;
  logic              w_capture;
  logic              w_timeout;
  logic              w_tmo_hit;

  // Current-record views: the inputs on the capture cycle, the latches after.
  logic [2:0]        w_dr_src;
  logic [DATA_W-1:0] w_alu_src;
  logic [DATA_W-1:0] w_pc_src;
  logic [DATA_W-1:0] w_mdata_src;
  logic [1:0]        w_wctl_src;
  logic              w_store_src;
  logic [DATA_W-1:0] w_mem_data;

  logic [DATA_W-1:0] w_nxt_addr;
  logic [DATA_W-1:0] w_nxt_din;
  logic              w_nxt_rd;
  logic              w_nxt_req;
  logic              w_nxt_wb_valid;
  logic              w_nxt_wb_en;
  logic [2:0]        w_nxt_wb_dr;
  logic [DATA_W-1:0] w_nxt_wb_data;

  logic              w_unused_ir;

  assign w_unused_ir = ^IR_Exec[8:0];
  assign w_dec       = f_decode(IR_Exec[15:12], Mem_Control_in);

  assign w_dr_src    = w_capture ? IR_Exec[11:9] : r_ir_dr;
  assign w_alu_src   = w_capture ? aluout        : r_alu;
  assign w_pc_src    = w_capture ? pcout         : r_pc;
  assign w_mdata_src = w_capture ? M_Data        : r_mdata;
  assign w_wctl_src  = w_capture ? W_Control_in  : r_wctl;
  assign w_store_src = w_capture ? w_dec[0]      : r_is_store;

  // Read data is only meaningful on the completing cycle of a load access.
  assign w_mem_data  = ((r_state == S_ACCESS) && !r_is_store) ? Data_dout : '0;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] r_wait_cnt;
  logic       r_mem_err;

  // Wait-state counter: counts unanswered request cycles within one phase.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wait_cnt <= 8'd0;
      r_mem_err  <= 1'b0;
    end else begin
      if (w_nxt_state != r_state) begin
        r_wait_cnt <= 8'd0;
      end else if ((r_state == S_IND_RD) || (r_state == S_ACCESS)) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end else begin
        r_wait_cnt <= 8'd0;
      end
      if (w_timeout) begin
        r_mem_err <= 1'b1;
      end else begin
        r_mem_err <= r_mem_err;
      end
    end
  end

  // The last allowed request cycle is the one where the count reaches limit-1.
  assign w_tmo_hit = (r_wait_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign mem_err   = r_mem_err;
`else
  assign w_tmo_hit = 1'b0;
  assign mem_err   = 1'b0;
`endif

  // Next-state logic; Data_ready is only looked at in the requesting states.
  always_comb begin
    w_nxt_state = r_state;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable_mem) begin
          w_capture = 1'b1;
          if (!w_dec[2]) begin
            w_nxt_state = S_WB;
          end else if (w_dec[1]) begin
            w_nxt_state = S_IND_RD;
          end else begin
            w_nxt_state = S_ACCESS;
          end
        end else begin
          w_nxt_state = S_IDLE;
        end
      end
      S_IND_RD, S_ACCESS: begin
        if (Data_ready) begin
          w_nxt_state = (r_state == S_IND_RD) ? S_ACCESS : S_WB;
        end else if (w_tmo_hit) begin
          w_nxt_state = S_WB;
          w_timeout   = 1'b1;
        end else begin
          w_nxt_state = r_state;
        end
      end
      S_WB:    w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, keyed on the state being entered.
  always_comb begin
    w_nxt_addr     = r_data_addr;
    w_nxt_din      = r_data_din;
    w_nxt_rd       = r_data_rd;
    w_nxt_req      = 1'b0;
    w_nxt_wb_valid = 1'b0;
    w_nxt_wb_en    = 1'b0;
    w_nxt_wb_dr    = r_wb_dr;
    w_nxt_wb_data  = r_wb_data;
    case (w_nxt_state)
      S_IND_RD: begin
        w_nxt_req  = 1'b1;
        w_nxt_rd   = 1'b1;
        w_nxt_addr = w_pc_src;
        w_nxt_din  = w_mdata_src;
      end
      S_ACCESS: begin
        w_nxt_req = 1'b1;
        w_nxt_rd  = ~w_store_src;
        w_nxt_din = w_mdata_src;
        // Pointer from the indirect read, else hold an open access, else pcout
        if (r_state == S_IND_RD) begin
          w_nxt_addr = Data_dout;
        end else if (r_state == S_ACCESS) begin
          w_nxt_addr = r_data_addr;
        end else begin
          w_nxt_addr = w_pc_src;
        end
      end
      S_WB: begin
        w_nxt_wb_valid = 1'b1;
        w_nxt_wb_en    = ~w_timeout & ~w_store_src;
        w_nxt_wb_dr    = w_dr_src;
        if (w_timeout) begin
          w_nxt_wb_data = '0;
        end else begin
          w_nxt_wb_data = f_wb_sel(w_wctl_src, w_alu_src, w_mem_data, w_pc_src);
        end
      end
      default: begin
        w_nxt_req = 1'b0;
      end
    endcase
  end

  // State, record latches and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ir_dr     <= 3'd0;
      r_alu       <= '0;
      r_pc        <= '0;
      r_mdata     <= '0;
      r_wctl      <= 2'b00;
      r_is_store  <= 1'b0;
      r_data_addr <= '0;
      r_data_din  <= '0;
      r_data_rd   <= 1'b0;
      r_data_req  <= 1'b0;
      r_mem_stall <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_en     <= 1'b0;
      r_wb_dr     <= 3'd0;
      r_wb_data   <= '0;
    end else begin
      r_state <= w_nxt_state;
      if (w_capture) begin
        r_ir_dr    <= IR_Exec[11:9];
        r_alu      <= aluout;
        r_pc       <= pcout;
        r_mdata    <= M_Data;
        r_wctl     <= W_Control_in;
        r_is_store <= w_dec[0];
      end
      r_data_addr <= w_nxt_addr;
      r_data_din  <= w_nxt_din;
      r_data_rd   <= w_nxt_rd;
      r_data_req  <= w_nxt_req;
      r_mem_stall <= (w_nxt_state != S_IDLE);
      r_wb_valid  <= w_nxt_wb_valid;
      r_wb_en     <= w_nxt_wb_en;
      r_wb_dr     <= w_nxt_wb_dr;
      r_wb_data   <= w_nxt_wb_data;
    end
  end

  assign Data_addr = r_data_addr;
  assign Data_din  = r_data_din;
  assign Data_rd   = r_data_rd;
  assign Data_req  = r_data_req;
  assign mem_stall = r_mem_stall;
  assign wb_valid  = r_wb_valid;
  assign wb_en     = r_wb_en;
  assign wb_dr     = r_wb_dr;
  assign wb_data   = r_wb_data;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_mem;
  logic [15:0] IR_Exec;
  logic [15:0] aluout;
  logic [15:0] pcout;
  logic [15:0] M_Data;
  logic [1:0]  W_Control_in;
  logic        Mem_Control_in;
  logic [15:0] Data_dout;
  logic        Data_ready;
  logic [15:0] Data_addr;
  logic [15:0] Data_din;
  logic        Data_rd;
  logic        Data_req;
  logic        mem_stall;
  logic        wb_valid;
  logic        wb_en;
  logic [2:0]  wb_dr;
  logic [15:0] wb_data;
  logic        mem_err;

  int total = 0;
  int bad   = 0;

  mem_access_unit #(.DATA_W(16), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .enable_mem(enable_mem), .IR_Exec(IR_Exec),
    .aluout(aluout), .pcout(pcout), .M_Data(M_Data), .W_Control_in(W_Control_in),
    .Mem_Control_in(Mem_Control_in), .Data_dout(Data_dout), .Data_ready(Data_ready),
    .Data_addr(Data_addr), .Data_din(Data_din), .Data_rd(Data_rd), .Data_req(Data_req),
    .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_en(wb_en), .wb_dr(wb_dr),
    .wb_data(wb_data), .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  task automatic drive_op(input logic [15:0] ir, input logic [15:0] alu, input logic [15:0] pc,
                          input logic [15:0] md, input logic [1:0] wc, input logic mc);
    IR_Exec = ir; aluout = alu; pcout = pc; M_Data = md; W_Control_in = wc; Mem_Control_in = mc;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable_mem = 1'b0; Data_ready = 1'b0; Data_dout = 16'h0000;
    drive_op(16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    total++; if (Data_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0h exp=0", Data_req); end
    total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0h exp=0", mem_stall); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%0h exp=0", wb_valid); end
    total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL reset_wb_en got=%0h exp=0", wb_en); end
    total++; if (wb_data !== 16'h0000) begin bad++; $display("FAIL reset_wb_data got=%h exp=0000", wb_data); end
    total++; if (wb_dr !== 3'd0) begin bad++; $display("FAIL reset_wb_dr got=%0d exp=0", wb_dr); end
    total++; if (Data_addr !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h exp=0000", Data_addr); end
    total++; if (mem_err !== 1'b0) begin bad++; $display("FAIL reset_mem_err got=%0h exp=0", mem_err); end
  endtask

  task automatic test_nonmem();
    @(posedge clock); #1;
    drive_op(16'h1283, 16'h0042, 16'h1111, 16'h2222, 2'b00, 1'b0); enable_mem = 1'b1;
    @(posedge clock); #1;
    enable_mem = 1'b0; drive_op(16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0);
    @(negedge clock);
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL add_wb_valid got=%0h exp=1", wb_valid); end
    total++; if (wb_dr !== 3'd1) begin bad++; $display("FAIL add_wb_dr got=%0d exp=1", wb_dr); end
    total++; if (wb_data !== 16'h0042) begin bad++; $display("FAIL add_wb_data got=%h exp=0042", wb_data); end
    total++; if (wb_en !== 1'b1) begin bad++; $display("FAIL add_wb_en got=%0h exp=1", wb_en); end
    total++; if (Data_req !== 1'b0) begin bad++; $display("FAIL add_req got=%0h exp=0", Data_req); end
    total++; if (mem_stall !== 1'b1) begin bad++; $display("FAIL add_stall got=%0h exp=1", mem_stall); end
    @(posedge clock); #1;
    @(negedge clock);
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL add_valid_drop got=%0h exp=0", wb_valid); end
    total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL add_en_drop got=%0h exp=0", wb_en); end
    total++; if (wb_data !== 16'h0042) begin bad++; $display("FAIL add_data_hold got=%h exp=0042", wb_data); end
    total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL add_stall_drop got=%0h exp=0", mem_stall); end
  endtask

  task automatic test_ld_wait();
    int req_cnt = 0;
    int stall_cnt = 0;
    int wb_cyc = -1;
    logic [15:0] got_data = 16'h0000;
    logic [2:0]  got_dr = 3'd0;
    logic        got_en = 1'b0;
    @(posedge clock); #1;
    drive_op(16'h2405, 16'h0101, 16'h3010, 16'h0000, 2'b01, 1'b1); enable_mem = 1'b1;
    @(posedge clock); #1;
    enable_mem = 1'b0; drive_op(16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0);
    for (int c = 0; c < 6; c++) begin
      Data_ready = (c == 2);
      Data_dout  = (c == 2) ? 16'hBEEF : 16'h0000;
      @(negedge clock);
      if (Data_req) req_cnt++;
      if (mem_stall) stall_cnt++;
      if (wb_valid && wb_cyc < 0) begin wb_cyc = c; got_data = wb_data; got_dr = wb_dr; got_en = wb_en; end
      if (c == 0) begin
        total++; if (Data_addr !== 16'h3010) begin bad++; $display("FAIL ld_addr got=%h exp=3010", Data_addr); end
        total++; if (Data_rd !== 1'b1) begin bad++; $display("FAIL ld_rd got=%0h exp=1", Data_rd); end
      end
      @(posedge clock); #1;
    end
    Data_ready = 1'b0; Data_dout = 16'h0000;
    total++; if (req_cnt !== 3) begin bad++; $display("FAIL ld_req_cycles got=%0d exp=3", req_cnt); end
    total++; if (stall_cnt !== 4) begin bad++; $display("FAIL ld_stall_cycles got=%0d exp=4", stall_cnt); end
    total++; if (wb_cyc !== 3) begin bad++; $display("FAIL ld_wb_cycle got=%0d exp=3", wb_cyc); end
    total++; if (got_data !== 16'hBEEF) begin bad++; $display("FAIL ld_wb_data got=%h exp=beef", got_data); end
    total++; if (got_dr !== 3'd2) begin bad++; $display("FAIL ld_wb_dr got=%0d exp=2", got_dr); end
    total++; if (got_en !== 1'b1) begin bad++; $display("FAIL ld_wb_en got=%0h exp=1", got_en); end
  endtask

  task automatic test_sti_zero_wait();
    @(posedge clock); #1;
    drive_op(16'hB7FF, 16'h0777, 16'h4000, 16'h1234, 2'b00, 1'b1); enable_mem = 1'b1;
    @(posedge clock); #1;
    enable_mem = 1'b0; drive_op(16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0);
    Data_ready = 1'b1; Data_dout = 16'h5000;
    @(negedge clock);
    total++; if (Data_req !== 1'b1) begin bad++; $display("FAIL sti_p1_req got=%0h exp=1", Data_req); end
    total++; if (Data_addr !== 16'h4000) begin bad++; $display("FAIL sti_p1_addr got=%h exp=4000", Data_addr); end
    total++; if (Data_rd !== 1'b1) begin bad++; $display("FAIL sti_p1_rd got=%0h exp=1", Data_rd); end
    @(posedge clock); #1;
    Data_dout = 16'hFFFF;
    @(negedge clock);
    total++; if (Data_req !== 1'b1) begin bad++; $display("FAIL sti_p2_req got=%0h exp=1", Data_req); end
    total++; if (Data_addr !== 16'h5000) begin bad++; $display("FAIL sti_p2_addr got=%h exp=5000", Data_addr); end
    total++; if (Data_din !== 16'h1234) begin bad++; $display("FAIL sti_p2_din got=%h exp=1234", Data_din); end
    total++; if (Data_rd !== 1'b0) begin bad++; $display("FAIL sti_p2_rd got=%0h exp=0", Data_rd); end
    @(posedge clock); #1;
    @(negedge clock);
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL sti_wb_valid got=%0h exp=1", wb_valid); end
    total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL sti_wb_en got=%0h exp=0", wb_en); end
    total++; if (wb_dr !== 3'd3) begin bad++; $display("FAIL sti_wb_dr got=%0d exp=3", wb_dr); end
    total++; if (Data_req !== 1'b0) begin bad++; $display("FAIL sti_wb_req got=%0h exp=0", Data_req); end
    @(posedge clock); #1;
    @(negedge clock);
    total++; if (Data_req !== 1'b0) begin bad++; $display("FAIL sti_idle_req got=%0h exp=0", Data_req); end
    total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL sti_idle_stall got=%0h exp=0", mem_stall); end
    Data_ready = 1'b0; Data_dout = 16'h0000;
  endtask

  task automatic test_reset_mid_access();
    @(posedge clock); #1;
    drive_op(16'h6A00, 16'h0000, 16'h2000, 16'h0000, 2'b01, 1'b1); enable_mem = 1'b1;
    @(posedge clock); #1;
    enable_mem = 1'b0; drive_op(16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0);
    @(negedge clock);
    total++; if (Data_req !== 1'b1) begin bad++; $display("FAIL rst_mid_wait1_req got=%0h exp=1", Data_req); end
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    total++; if (Data_req !== 1'b1) begin bad++; $display("FAIL rst_mid_wait2_req got=%0h exp=1", Data_req); end
    @(posedge clock); #1;
    reset = 1'b0;
    drive_op(16'h1E05, 16'h00AA, 16'h0000, 16'h0000, 2'b00, 1'b0); enable_mem = 1'b1;
    @(negedge clock);
    total++; if (Data_req !== 1'b0) begin bad++; $display("FAIL rst_mid_req got=%0h exp=0", Data_req); end
    total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL rst_mid_stall got=%0h exp=0", mem_stall); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_wb_valid got=%0h exp=0", wb_valid); end
    @(posedge clock); #1;
    enable_mem = 1'b0;
    @(negedge clock);
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL rst_new_wb_valid got=%0h exp=1", wb_valid); end
    total++; if (wb_data !== 16'h00AA) begin bad++; $display("FAIL rst_new_wb_data got=%h exp=00aa", wb_data); end
    total++; if (wb_dr !== 3'd7) begin bad++; $display("FAIL rst_new_wb_dr got=%0d exp=7", wb_dr); end
    @(posedge clock); #1;
  endtask

  task automatic test_enable_during_access();
    @(posedge clock); #1;
    drive_op(16'h2C00, 16'h0000, 16'h5555, 16'h0000, 2'b01, 1'b1); enable_mem = 1'b1;
    @(posedge clock); #1;
    drive_op(16'h3000, 16'h4444, 16'h7777, 16'h9999, 2'b00, 1'b1);
    for (int c = 0; c < 6; c++) begin
      enable_mem = (c < 4);
      Data_ready = (c == 2);
      Data_dout  = (c == 2) ? 16'h1357 : 16'h0000;
      @(negedge clock);
      if (c < 2) begin
        total++; if (Data_addr !== 16'h5555) begin bad++; $display("FAIL en_tog_addr c=%0d got=%h exp=5555", c, Data_addr); end
        total++; if (Data_rd !== 1'b1) begin bad++; $display("FAIL en_tog_rd c=%0d got=%0h exp=1", c, Data_rd); end
      end
      if (c == 3) begin
        total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL en_tog_wb_valid got=%0h exp=1", wb_valid); end
        total++; if (wb_data !== 16'h1357) begin bad++; $display("FAIL en_tog_wb_data got=%h exp=1357", wb_data); end
        total++; if (wb_dr !== 3'd6) begin bad++; $display("FAIL en_tog_wb_dr got=%0d exp=6", wb_dr); end
        total++; if (wb_en !== 1'b1) begin bad++; $display("FAIL en_tog_wb_en got=%0h exp=1", wb_en); end
      end
      if (c >= 4) begin
        total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL en_tog_stall c=%0d got=%0h exp=0", c, mem_stall); end
        total++; if (Data_req !== 1'b0) begin bad++; $display("FAIL en_tog_req c=%0d got=%0h exp=0", c, Data_req); end
      end
      @(posedge clock); #1;
    end
    Data_ready = 1'b0; Data_dout = 16'h0000; enable_mem = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] t_ir  [4] = '{16'h1A01, 16'h5E3F, 16'h2405, 16'h0FFF};
    logic [15:0] t_alu [4] = '{16'h0099, 16'h1111, 16'h7E57, 16'h8000};
    logic [1:0]  t_wc  [4] = '{2'b11, 2'b10, 2'b00, 2'b00};
    logic [15:0] t_exp [4] = '{16'h0099, 16'hABCD, 16'h7E57, 16'h8000};
    logic [2:0]  t_dr  [4] = '{3'd5, 3'd7, 3'd2, 3'd7};
    @(posedge clock); #1;
    for (int k = 0; k < 4; k++) begin
      drive_op(t_ir[k], t_alu[k], 16'hABCD, 16'h0000, t_wc[k], 1'b0); enable_mem = 1'b1;
      @(negedge clock);
      total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL b2b_idle_stall k=%0d got=%0h exp=0", k, mem_stall); end
      @(posedge clock); #1;
      drive_op(16'h2000, 16'hDEAD, 16'h0BAD, 16'h0000, 2'b01, 1'b1);
      @(negedge clock);
      total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL b2b_wb_valid k=%0d got=%0h exp=1", k, wb_valid); end
      total++; if (wb_data !== t_exp[k]) begin bad++; $display("FAIL b2b_wb_data k=%0d got=%h exp=%h", k, wb_data, t_exp[k]); end
      total++; if (wb_dr !== t_dr[k]) begin bad++; $display("FAIL b2b_wb_dr k=%0d got=%0d exp=%0d", k, wb_dr, t_dr[k]); end
      total++; if (wb_en !== 1'b1) begin bad++; $display("FAIL b2b_wb_en k=%0d got=%0h exp=1", k, wb_en); end
      total++; if (Data_req !== 1'b0) begin bad++; $display("FAIL b2b_req k=%0d got=%0h exp=0", k, Data_req); end
      @(posedge clock); #1;
    end
    enable_mem = 1'b0;
    @(negedge clock);
    total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL b2b_final_stall got=%0h exp=0", mem_stall); end
  endtask

  task automatic test_timeout();
    int req_cnt = 0;
    int wb_cyc = -1;
    logic [15:0] got_data = 16'hFFFF;
    logic        got_en = 1'b1;
    logic        got_err = 1'b0;
    @(posedge clock); #1;
    drive_op(16'h2405, 16'h0101, 16'h6000, 16'h0000, 2'b01, 1'b1); enable_mem = 1'b1;
    @(posedge clock); #1;
    enable_mem = 1'b0; drive_op(16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0);
    Data_ready = 1'b0; Data_dout = 16'h0000;
`ifdef MEM_TIMEOUT_EN
    for (int c = 0; c < 24; c++) begin
      @(negedge clock);
      if (Data_req) req_cnt++;
      if (wb_valid && wb_cyc < 0) begin wb_cyc = c; got_data = wb_data; got_en = wb_en; got_err = mem_err; end
      @(posedge clock); #1;
    end
    total++; if (req_cnt !== 16) begin bad++; $display("FAIL tmo_req_cycles got=%0d exp=16", req_cnt); end
    total++; if (wb_cyc !== 16) begin bad++; $display("FAIL tmo_wb_cycle got=%0d exp=16", wb_cyc); end
    total++; if (got_en !== 1'b0) begin bad++; $display("FAIL tmo_wb_en got=%0h exp=0", got_en); end
    total++; if (got_data !== 16'h0000) begin bad++; $display("FAIL tmo_wb_data got=%h exp=0000", got_data); end
    total++; if (got_err !== 1'b1) begin bad++; $display("FAIL tmo_mem_err got=%0h exp=1", got_err); end
    drive_op(16'h1283, 16'h0042, 16'h0000, 16'h0000, 2'b00, 1'b0); enable_mem = 1'b1;
    @(posedge clock); #1;
    enable_mem = 1'b0;
    @(negedge clock);
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL tmo_next_wb_valid got=%0h exp=1", wb_valid); end
    @(posedge clock); #1;
    @(negedge clock);
    total++; if (mem_err !== 1'b1) begin bad++; $display("FAIL tmo_err_sticky got=%0h exp=1", mem_err); end
`else
    for (int c = 0; c < 30; c++) begin
      Data_ready = (c == 29);
      Data_dout  = (c == 29) ? 16'hC0DE : 16'h0000;
      @(negedge clock);
      if (Data_req) req_cnt++;
      @(posedge clock); #1;
    end
    Data_ready = 1'b0; Data_dout = 16'h0000;
    @(negedge clock);
    total++; if (req_cnt !== 30) begin bad++; $display("FAIL nowait_req_cycles got=%0d exp=30", req_cnt); end
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL nowait_wb_valid got=%0h exp=1", wb_valid); end
    total++; if (wb_data !== 16'hC0DE) begin bad++; $display("FAIL nowait_wb_data got=%h exp=c0de", wb_data); end
    total++; if (mem_err !== 1'b0) begin bad++; $display("FAIL nowait_mem_err got=%0h exp=0", mem_err); end
    @(posedge clock); #1;
`endif
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_ld_wait();
    test_sti_zero_wait();
    test_reset_mid_access();
    test_enable_during_access();
    test_back_to_back();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
